// File: rtl/uart_axil_sequencer_pkg.sv
// uart_axil_sequencer_pkg
// Shared definitions for the UART AXI-Lite sequencer: UART slave register
// map, status word bit positions and the sequencer FSM state encoding.
package uart_axil_sequencer_pkg;

  // UART AXI-Lite slave register map
  localparam int unsigned UART_ADDR_DVSR = 1;
  localparam int unsigned UART_ADDR_TX   = 2;
  localparam int unsigned UART_ADDR_STAT = 3;

  // Bit positions inside the RX/status word
  localparam int unsigned RX_EMPTY_BIT = 8;
  localparam int unsigned TX_FULL_BIT  = 9;

  typedef enum logic [2:0] {
    ST_BOOT = 3'd0,
    ST_IDLE = 3'd1,
    ST_AW   = 3'd2,
    ST_W    = 3'd3,
    ST_B    = 3'd4,
    ST_AR   = 3'd5,
    ST_R    = 3'd6
  } seq_state_t;

endpackage

// File: rtl/uart_axil_sequencer_if.sv
// uart_axil_sequencer_if
// AXI-Lite bus between the sequencer (master) and the UART register slave.
// Ports: write address (awaddr/awvalid/awready), write data
// (wdata/wstrb/wvalid/wready), write response (bvalid/bready), read address
// (araddr/arvalid/arready) and read data (rdata/rvalid/rready).
interface uart_axil_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bvalid, arready, rdata, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bvalid, arready, rdata, rvalid
  );

endinterface

// File: rtl/uart_axil_sequencer_rr_arbiter2.sv
// rr_arbiter2
// Two-requester round-robin arbiter. The grant is combinational from the
// requests and the priority pointer; the pointer only moves when the grant
// is actually taken (accept), so an unserved winner keeps its turn.
// Ports: clk, resetn (async, active-high), req[1:0], accept, grant[1:0].
module rr_arbiter2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // High when requester 1 has priority; requester 0 is favoured after reset
  logic prio_one;

  always_comb begin
    grant = 2'b00;
    if (req[0] && (!prio_one || !req[1])) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end

  // Pointer moves past whichever requester was just served
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      prio_one <= 1'b0;
    end else if (accept && (grant != 2'b00)) begin
      prio_one <= grant[0];
    end
  end

endmodule

// File: rtl/uart_axil_sequencer.sv
// uart_axil_sequencer
// AXI-Lite master owning the UART register slave. After reset it writes the
// boot divisor, then serves runtime divisor updates, periodic RX/status polls
// and two round-robin byte-stream TX clients, one transaction at a time.
// Ports:
//   clk, resetn            clock, asynchronous active-high reset
//   cfg_valid/ready/dvsr   runtime divisor update
//   txN_valid/ready/data   TX client byte streams (N = 0, 1)
//   rx_valid/ready/data    received-byte stream
//   busy                   sequencer is mid-transaction
//   axi                    AXI-Lite master port to the UART slave
module uart_axil_sequencer
  import uart_axil_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DVSR_INIT   = 650,
  parameter int POLL_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [10:0] cfg_dvsr,
  input  logic        tx0_valid,
  output logic        tx0_ready,
  input  logic [7:0]  tx0_data,
  input  logic        tx1_valid,
  output logic        tx1_ready,
  input  logic [7:0]  tx1_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        busy,
  uart_axil_sequencer_if.master axi
);

  localparam int CNT_W = $clog2(POLL_CYCLES);
  localparam logic [CNT_W-1:0] POLL_RELOAD = CNT_W'(POLL_CYCLES - 1);

  seq_state_t            state;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;
  logic                  rx_valid_q;
  logic [7:0]            rx_data_q;
  logic                  busy_q;
  logic                  tx_full_seen;
  logic                  poll_pending;
  logic [CNT_W-1:0]      poll_cnt;

  logic                  sel_cfg;
  logic                  sel_poll;
  logic                  sel_tx;
  logic [1:0]            tx_grant;
  logic [7:0]            tx_byte;

  // IDLE arbitration: cfg beats poll beats TX, all decided in one cycle
  always_comb begin
    sel_cfg  = (state == ST_IDLE) && cfg_valid;
    sel_poll = (state == ST_IDLE) && !cfg_valid && poll_pending && !rx_valid_q;
    sel_tx   = (state == ST_IDLE) && !cfg_valid && !(poll_pending && !rx_valid_q)
               && !tx_full_seen && (tx0_valid || tx1_valid);
    tx_byte  = tx_grant[1] ? tx1_data : tx0_data;
  end

  rr_arbiter2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    ({tx1_valid, tx0_valid}),
    .accept (sel_tx),
    .grant  (tx_grant)
  );

  assign cfg_ready = sel_cfg;
  assign tx0_ready = sel_tx && tx_grant[0];
  assign tx1_ready = sel_tx && tx_grant[1];

  assign axi.awaddr  = awaddr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = '1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.araddr  = araddr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;

  // Free-running poll timer. A stale TX-full flag re-arms the poll on every
  // IDLE cycle; entering AR (sel_poll) takes precedence and clears it.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      poll_cnt     <= POLL_RELOAD;
      poll_pending <= 1'b0;
    end else begin
      if (poll_cnt == '0) begin
        poll_cnt <= POLL_RELOAD;
      end else begin
        poll_cnt <= poll_cnt - 1'b1;
      end
      if ((poll_cnt == '0) || ((state == ST_IDLE) && tx_full_seen)) begin
        poll_pending <= 1'b1;
      end
      if (sel_poll) begin
        poll_pending <= 1'b0;
      end
    end
  end

  // Transaction FSM. busy is registered alongside the state so it reads 0
  // during reset and BOOT, and follows state != IDLE from then on.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state        <= ST_BOOT;
      awaddr_q     <= '0;
      araddr_q     <= '0;
      wdata_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      tx_full_seen <= 1'b0;
    end else begin
      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      case (state)
        ST_BOOT: begin
          awaddr_q  <= ADDR_WIDTH'(UART_ADDR_DVSR);
          wdata_q   <= DATA_WIDTH'(DVSR_INIT);
          awvalid_q <= 1'b1;
          busy_q    <= 1'b1;
          state     <= ST_AW;
        end
        ST_IDLE: begin
          if (sel_cfg) begin
            awaddr_q  <= ADDR_WIDTH'(UART_ADDR_DVSR);
            wdata_q   <= DATA_WIDTH'(cfg_dvsr);
            awvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            state     <= ST_AW;
          end else if (sel_poll) begin
            araddr_q  <= ADDR_WIDTH'(UART_ADDR_STAT);
            arvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            state     <= ST_AR;
          end else if (sel_tx) begin
            awaddr_q  <= ADDR_WIDTH'(UART_ADDR_TX);
            wdata_q   <= DATA_WIDTH'(tx_byte);
            awvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            state     <= ST_AW;
          end
        end
        ST_AW: begin
          if (axi.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            state     <= ST_W;
          end
        end
        ST_W: begin
          if (axi.wready) begin
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            state    <= ST_B;
          end
        end
        ST_B: begin
          if (axi.bvalid) begin
            bready_q <= 1'b0;
            busy_q   <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_AR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_R;
          end
        end
        ST_R: begin
          if (axi.rvalid) begin
            rready_q     <= 1'b0;
            busy_q       <= 1'b0;
            state        <= ST_IDLE;
            tx_full_seen <= axi.rdata[TX_FULL_BIT];
            if (!axi.rdata[RX_EMPTY_BIT]) begin
              rx_data_q  <= axi.rdata[7:0];
              rx_valid_q <= 1'b1;
            end
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_axil_sequencer.sv
// tb_uart_axil_sequencer
// Directed bench for uart_axil_sequencer with a zero-wait AXI-Lite UART slave
// model that logs every completed write and answers status reads with a
// bench-controlled status word.
module tb_uart_axil_sequencer;

  logic        clk;
  logic        resetn;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [10:0] cfg_dvsr;
  logic        tx0_valid;
  logic        tx0_ready;
  logic [7:0]  tx0_data;
  logic        tx1_valid;
  logic        tx1_ready;
  logic [7:0]  tx1_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        busy;

  int vectors;
  int miscompares;

  // Slave model state
  logic        wready_en;
  logic [31:0] stat_word;
  logic        s_bvalid;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic [31:0] aw_addr_q;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          ar_count;
  int          tx0_accepts;

  uart_axil_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi_bus ();

  uart_axil_sequencer #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .DVSR_INIT   (650),
    .POLL_CYCLES (32)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_dvsr  (cfg_dvsr),
    .tx0_valid (tx0_valid),
    .tx0_ready (tx0_ready),
    .tx0_data  (tx0_data),
    .tx1_valid (tx1_valid),
    .tx1_ready (tx1_ready),
    .tx1_data  (tx1_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .busy      (busy),
    .axi       (axi_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign axi_bus.awready = 1'b1;
  assign axi_bus.wready  = wready_en;
  assign axi_bus.bvalid  = s_bvalid;
  assign axi_bus.arready = 1'b1;
  assign axi_bus.rdata   = s_rdata;
  assign axi_bus.rvalid  = s_rvalid;

  always @(posedge clk or posedge resetn) begin
    if (resetn) begin
      s_bvalid  <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= 32'h0;
      aw_addr_q <= 32'h0;
    end else begin
      if (axi_bus.awvalid && axi_bus.awready) aw_addr_q <= axi_bus.awaddr;
      if (axi_bus.wvalid && axi_bus.wready) begin
        wr_addr.push_back(aw_addr_q);
        wr_data.push_back(axi_bus.wdata);
        s_bvalid <= 1'b1;
      end else if (s_bvalid && axi_bus.bready) begin
        s_bvalid <= 1'b0;
      end
      if (axi_bus.arvalid && axi_bus.arready) begin
        ar_count <= ar_count + 1;
        s_rdata  <= stat_word;
        s_rvalid <= 1'b1;
      end else if (s_rvalid && axi_bus.rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (tx0_valid && tx0_ready) tx0_accepts <= tx0_accepts + 1;
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, axi_bus.arvalid, axi_bus.rready} !== 5'b0) begin
      $display("[TB] FAIL reset_valids: got %b expected 00000",
               {axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, axi_bus.arvalid, axi_bus.rready});
      miscompares++;
    end
    vectors++;
    if ({axi_bus.awaddr, axi_bus.araddr, axi_bus.wdata} !== 96'h0) begin
      $display("[TB] FAIL reset_addr_data: got %h/%h/%h expected 0", axi_bus.awaddr, axi_bus.araddr, axi_bus.wdata);
      miscompares++;
    end
    vectors++;
    if ({rx_valid, rx_data, busy, cfg_ready, tx0_ready, tx1_ready} !== 13'h0) begin
      $display("[TB] FAIL reset_stream: rx_valid=%b rx_data=%h busy=%b cfg_ready=%b tx_ready=%b%b expected all 0",
               rx_valid, rx_data, busy, cfg_ready, tx1_ready, tx0_ready);
      miscompares++;
    end
  endtask

  task automatic test_boot();
    clear_log();
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (axi_bus.awvalid !== 1'b1 || axi_bus.awaddr !== 32'd1) begin
      $display("[TB] FAIL boot_aw: got awvalid=%b awaddr=%h expected 1/00000001", axi_bus.awvalid, axi_bus.awaddr);
      miscompares++;
    end
    vectors++;
    if (axi_bus.wdata !== 32'd650 || busy !== 1'b1) begin
      $display("[TB] FAIL boot_wdata_busy: got wdata=%0d busy=%b expected 650/1", axi_bus.wdata, busy);
      miscompares++;
    end
    @(posedge clk);
    #1;
    vectors++;
    if (axi_bus.wvalid !== 1'b1 || axi_bus.awvalid !== 1'b0) begin
      $display("[TB] FAIL boot_w_phase: got wvalid=%b awvalid=%b expected 1/0", axi_bus.wvalid, axi_bus.awvalid);
      miscompares++;
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      $display("[TB] FAIL boot_idle: got busy=%b expected 0", busy);
      miscompares++;
    end
    vectors++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 32'd1 || wr_data[0] !== 32'd650) begin
      $display("[TB] FAIL boot_write: got %0d writes first %h=%0d expected 1 write 00000001=650",
               wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 32'hx, (wr_data.size() > 0) ? wr_data[0] : 32'hx);
      miscompares++;
    end
  endtask

  task automatic test_arbitration();
    logic [7:0] expected_bytes [4];
    int n;
    expected_bytes[0] = 8'h41;
    expected_bytes[1] = 8'h42;
    expected_bytes[2] = 8'h41;
    expected_bytes[3] = 8'h42;
    @(negedge clk);
    clear_log();
    tx0_data  = 8'h41;
    tx1_data  = 8'h42;
    tx0_valid = 1'b1;
    tx1_valid = 1'b1;
    for (int i = 0; i < 300 && wr_addr.size() < 4; i++) @(negedge clk);
    tx0_valid = 1'b0;
    tx1_valid = 1'b0;
    n = wr_addr.size();
    vectors++;
    if (n < 4) begin
      $display("[TB] FAIL arb_timeout: got %0d writes expected 4", n);
      miscompares++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (wr_addr[i] !== 32'd2 || wr_data[i] !== {24'h0, expected_bytes[i]}) begin
          $display("[TB] FAIL arb_write%0d: got %h=%h expected 00000002=%h", i, wr_addr[i], wr_data[i], expected_bytes[i]);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_rx();
    int ar_snap;
    bit seen;
    @(negedge clk);
    rx_ready  = 1'b0;
    stat_word = 32'h0000_0008;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rx_valid) begin
        seen = 1'b1;
        break;
      end
    end
    stat_word = 32'h0000_0100;
    vectors++;
    if (!seen || rx_data !== 8'h08) begin
      $display("[TB] FAIL rx_byte: got rx_valid=%b rx_data=%h expected 1/08", rx_valid, rx_data);
      miscompares++;
    end
    ar_snap = ar_count;
    repeat (100) @(negedge clk);
    vectors++;
    if (ar_count != ar_snap || rx_valid !== 1'b1) begin
      $display("[TB] FAIL rx_hold: got %0d new reads rx_valid=%b expected 0 reads, rx_valid 1", ar_count - ar_snap, rx_valid);
      miscompares++;
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    vectors++;
    if (rx_valid !== 1'b0) begin
      $display("[TB] FAIL rx_consume: got rx_valid=%b expected 0", rx_valid);
      miscompares++;
    end
    for (int i = 0; i < 100 && ar_count == ar_snap; i++) @(negedge clk);
    vectors++;
    if (ar_count == ar_snap) begin
      $display("[TB] FAIL rx_poll_resume: got %0d reads after rx_ready expected at least 1", ar_count - ar_snap);
      miscompares++;
    end
  endtask

  task automatic test_backpressure();
    int ar_snap;
    int acc_snap;
    bit ok;
    wait_idle(ok);
    stat_word = 32'h0000_0300;
    ar_snap = ar_count;
    for (int i = 0; i < 100 && ar_count == ar_snap; i++) @(negedge clk);
    wait_idle(ok);
    vectors++;
    if (ar_count == ar_snap || !ok) begin
      $display("[TB] FAIL bp_poll: got %0d reads idle=%b expected a read then idle", ar_count - ar_snap, ok);
      miscompares++;
    end
    clear_log();
    acc_snap  = tx0_accepts;
    tx0_data  = 8'h55;
    tx0_valid = 1'b1;
    repeat (80) @(negedge clk);
    vectors++;
    if (wr_addr.size() != 0 || tx0_accepts != acc_snap) begin
      $display("[TB] FAIL bp_blocked: got %0d writes %0d accepts expected 0/0", wr_addr.size(), tx0_accepts - acc_snap);
      miscompares++;
    end
    stat_word = 32'h0000_0100;
    for (int i = 0; i < 100 && wr_addr.size() == 0; i++) @(negedge clk);
    tx0_valid = 1'b0;
    vectors++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 32'd2 || wr_data[0] !== 32'h55 || tx0_accepts != acc_snap + 1) begin
      $display("[TB] FAIL bp_resume: got %0d writes %0d accepts first %h expected 1 write 00000002=00000055",
               wr_addr.size(), tx0_accepts - acc_snap, (wr_data.size() > 0) ? wr_data[0] : 32'hx);
      miscompares++;
    end
  endtask

  task automatic test_config_race();
    bit ok;
    wait_idle(ok);
    clear_log();
    cfg_dvsr  = 11'd325;
    cfg_valid = 1'b1;
    tx0_data  = 8'h33;
    tx0_valid = 1'b1;
    #1;
    vectors++;
    if (!ok || cfg_ready !== 1'b1 || tx0_ready !== 1'b0) begin
      $display("[TB] FAIL race_select: got idle=%b cfg_ready=%b tx0_ready=%b expected 1/1/0", ok, cfg_ready, tx0_ready);
      miscompares++;
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    for (int i = 0; i < 200 && wr_addr.size() < 2; i++) @(negedge clk);
    tx0_valid = 1'b0;
    vectors++;
    if (wr_addr.size() < 2) begin
      $display("[TB] FAIL race_timeout: got %0d writes expected 2", wr_addr.size());
      miscompares++;
    end else begin
      vectors++;
      if (wr_addr[0] !== 32'd1 || wr_data[0] !== 32'd325) begin
        $display("[TB] FAIL race_first: got %h=%0d expected 00000001=325", wr_addr[0], wr_data[0]);
        miscompares++;
      end
      vectors++;
      if (wr_addr[1] !== 32'd2 || wr_data[1] !== 32'h33) begin
        $display("[TB] FAIL race_second: got %h=%h expected 00000002=00000033", wr_addr[1], wr_data[1]);
        miscompares++;
      end
    end
  endtask

  task automatic test_reset_in_w();
    bit ok;
    bit in_w;
    wait_idle(ok);
    wready_en = 1'b0;
    cfg_dvsr  = 11'd100;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    in_w = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axi_bus.wvalid) begin
        in_w = 1'b1;
        break;
      end
    end
    vectors++;
    if (!in_w) begin
      $display("[TB] FAIL rw_reach_w: got wvalid=%b expected 1", axi_bus.wvalid);
      miscompares++;
    end
    #2;
    resetn = 1'b1;
    #1;
    vectors++;
    if (axi_bus.wvalid !== 1'b0 || axi_bus.awvalid !== 1'b0 || busy !== 1'b0) begin
      $display("[TB] FAIL rw_async_clear: got wvalid=%b awvalid=%b busy=%b expected 0/0/0",
               axi_bus.wvalid, axi_bus.awvalid, busy);
      miscompares++;
    end
    @(negedge clk);
    clear_log();
    wready_en = 1'b1;
    resetn    = 1'b0;
    for (int i = 0; i < 50 && wr_addr.size() == 0; i++) @(negedge clk);
    vectors++;
    if (wr_addr.size() < 1 || wr_addr[0] !== 32'd1 || wr_data[0] !== 32'd650) begin
      $display("[TB] FAIL rw_reboot: got %0d writes first %h expected 00000001=650",
               wr_addr.size(), (wr_data.size() > 0) ? wr_data[0] : 32'hx);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ar_count    = 0;
    tx0_accepts = 0;
    resetn      = 1'b1;
    cfg_valid   = 1'b0;
    cfg_dvsr    = 11'd0;
    tx0_valid   = 1'b0;
    tx0_data    = 8'h00;
    tx1_valid   = 1'b0;
    tx1_data    = 8'h00;
    rx_ready    = 1'b0;
    wready_en   = 1'b1;
    stat_word   = 32'h0000_0100;

    test_reset();
    test_boot();
    test_arbitration();
    test_rx();
    test_backpressure();
    test_config_race();
    test_reset_in_w();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
